// File: rtl/game_tick_scheduler.sv
// game_tick_scheduler: central clock-enable generator for the game logic.
// Produces a prescaled base tick, a display refresh tick, and a
// level-dependent gravity request with a req/ack handshake.
// Ports:
//   clk_in        system clock
//   reset_n       synchronous active-low reset
//   en            game running; low forces IDLE
//   pause         freeze gravity while high
//   level[3:0]    current game level
//   soft_drop     use SOFT_PERIOD while high
//   drop_ack      piece controller consumed drop_req
//   base_tick     1-cycle pulse every PRESCALE cycles
//   refresh_tick  same as base_tick, also pulses while paused
//   drop_req      gravity request, held until acked
//   overrun       sticky: gravity fired while drop_req pending
//   state[1:0]    0=IDLE 1=RUN 2=PAUSED
module game_tick_scheduler #(
  parameter int unsigned PRESCALE     = 4,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned START_PERIOD = 10,
  parameter int unsigned STEP         = 1,
  parameter int unsigned MIN_PERIOD   = 2,
  parameter int unsigned SOFT_PERIOD  = 1
) (
  input  logic       clk_in,
  input  logic       reset_n,
  input  logic       en,
  input  logic       pause,
  input  logic [3:0] level,
  input  logic       soft_drop,
  input  logic       drop_ack,
  output logic       base_tick,
  output logic       refresh_tick,
  output logic       drop_req,
  output logic       overrun,
  output logic [1:0] state
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned AW = CNT_W + 4;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_PAUSED = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic             w_active;
  logic             w_grav_en;
  logic             w_leave_idle;

  logic [PW-1:0]    r_presc;
  logic [CNT_W-1:0] r_grav;
  logic             r_base_tick;
  logic             r_refresh_tick;
  logic             r_drop_req;
  logic             r_overrun;

  logic [AW-1:0]    w_lvl_dec;
  logic [AW-1:0]    w_period;
  logic [AW-1:0]    w_grav_inc;
  logic             w_grav_step;
  logic             w_fire;
  logic             w_presc_wrap;

  // State register
  always_ff @(posedge clk_in) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  // Next state: en has priority over pause
  always_comb begin
    w_next_state = S_IDLE;
    if (en) w_next_state = pause ? S_PAUSED : S_RUN;
  end

  // Control decode; en low stops all activity immediately so no tick
  // or request can leak into the first IDLE cycle
  always_comb begin
    w_active     = 1'b0;
    w_grav_en    = 1'b0;
    w_leave_idle = 1'b0;
    if (en) begin
      case (r_state)
        S_IDLE:   w_leave_idle = 1'b1;
        S_RUN: begin
          w_active  = 1'b1;
          w_grav_en = 1'b1;
        end
        S_PAUSED: w_active = 1'b1;
        default:  w_active = 1'b0;
      endcase
    end
  end

  // Gravity period, saturating at MIN_PERIOD instead of underflowing
  always_comb begin
    w_lvl_dec = AW'(level) * AW'(STEP);
    if (soft_drop)
      w_period = AW'(SOFT_PERIOD);
    else if (w_lvl_dec > AW'(START_PERIOD - MIN_PERIOD))
      w_period = AW'(MIN_PERIOD);
    else
      w_period = AW'(START_PERIOD) - w_lvl_dec;
  end

  // >= lets a shortened period fire on the next tick without waiting for wrap
  assign w_grav_inc   = AW'(r_grav) + AW'(1);
  assign w_grav_step  = w_grav_en & r_base_tick;
  assign w_fire       = w_grav_step & (w_grav_inc >= w_period);
  assign w_presc_wrap = (r_presc == PW'(PRESCALE - 1));

  // Prescaler, ticks, gravity counter and request handshake
  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      r_presc        <= '0;
      r_base_tick    <= 1'b0;
      r_refresh_tick <= 1'b0;
      r_grav         <= '0;
      r_drop_req     <= 1'b0;
    end else if (!w_active) begin
      r_presc        <= '0;
      r_base_tick    <= 1'b0;
      r_refresh_tick <= 1'b0;
      r_grav         <= '0;
      r_drop_req     <= 1'b0;
    end else begin
      r_presc        <= w_presc_wrap ? '0 : r_presc + PW'(1);
      r_base_tick    <= w_presc_wrap;
      r_refresh_tick <= w_presc_wrap;
      if (w_grav_step) r_grav <= w_fire ? '0 : r_grav + CNT_W'(1);
      // A fire coinciding with an ack re-arms the request
      if (w_fire)        r_drop_req <= 1'b1;
      else if (drop_ack) r_drop_req <= 1'b0;
    end
  end

  // Sticky overrun, cleared when the game restarts from IDLE
  always_ff @(posedge clk_in) begin
    if (!reset_n)
      r_overrun <= 1'b0;
    else if (w_leave_idle)
      r_overrun <= 1'b0;
    else if (w_fire && r_drop_req && !drop_ack)
      r_overrun <= 1'b1;
  end

  assign base_tick    = r_base_tick;
  assign refresh_tick = r_refresh_tick;
  assign drop_req     = r_drop_req;
  assign overrun      = r_overrun;
  assign state        = r_state;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Bench for game_tick_scheduler: behavioural model compared every cycle,
// directed scenarios with literal timing expectations, then random traffic.
module tb_game_tick_scheduler;

  localparam int PRESCALE = 4;
  localparam int START    = 10;
  localparam int STEP     = 1;
  localparam int MINP     = 2;
  localparam int SOFTP    = 1;

  logic       clk_in = 1'b0;
  logic       reset_n, en, pause, soft_drop, drop_ack;
  logic [3:0] level;
  logic       base_tick, refresh_tick, drop_req, overrun;
  logic [1:0] state;

  always #5 clk_in = ~clk_in;

  game_tick_scheduler dut (
    .clk_in       (clk_in),
    .reset_n      (reset_n),
    .en           (en),
    .pause        (pause),
    .level        (level),
    .soft_drop    (soft_drop),
    .drop_ack     (drop_ack),
    .base_tick    (base_tick),
    .refresh_tick (refresh_tick),
    .drop_req     (drop_req),
    .overrun      (overrun),
    .state        (state)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model state: mode, active-cycle count, gravity count, outputs
  int m_state, m_act, m_grav;
  bit m_bt, m_req, m_ovr;

  bit auto_ack = 0;
  bit prev_req = 0;
  int rise_cnt = 0, rise_last = 0, rise_prev = 0;
  int bt_first = -1;

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, actual, expected);
    end
  endtask

  // Advance the model by one clock from the inputs present at the edge
  task automatic model_step();
    int p;
    bit act, run_tick, fire;
    if (!reset_n) begin
      m_state = 0; m_act = 0; m_grav = 0; m_bt = 0; m_req = 0; m_ovr = 0;
      return;
    end
    act      = en && (m_state != 0);
    run_tick = act && (m_state == 1) && m_bt;
    if (soft_drop) p = SOFTP;
    else begin
      p = START - int'(level) * STEP;
      if (p < MINP) p = MINP;
    end
    fire = run_tick && (m_grav + 1 >= p);
    if (m_state == 0 && en) m_ovr = 0;
    else if (fire && m_req && !drop_ack) m_ovr = 1;
    if (!act) m_req = 0;
    else if (fire) m_req = 1;
    else if (drop_ack) m_req = 0;
    if (!act) m_grav = 0;
    else if (run_tick) m_grav = fire ? 0 : m_grav + 1;
    if (act) begin
      m_act++;
      m_bt = (m_act % PRESCALE) == 0;
    end else begin
      m_act = 0;
      m_bt  = 0;
    end
    m_state = !en ? 0 : (pause ? 2 : 1);
  endtask

  task automatic step();
    @(posedge clk_in);
    model_step();
    #1;
    cyc++;
    chk("state", int'(state), m_state);
    chk("base_tick", int'(base_tick), int'(m_bt));
    chk("refresh_tick", int'(refresh_tick), int'(m_bt));
    chk("drop_req", int'(drop_req), int'(m_req));
    chk("overrun", int'(overrun), int'(m_ovr));
    if (drop_req && !prev_req) begin
      rise_prev = rise_last;
      rise_last = cyc;
      rise_cnt++;
    end
    prev_req = drop_req;
    if (base_tick && bt_first < 0) bt_first = cyc;
    if (auto_ack) drop_ack = drop_req;
  endtask

  // Spacing between the last two of three fresh drop_req rises
  task automatic measure(input string name, input int expected);
    int start;
    start = rise_cnt;
    for (int i = 0; i < 400 && rise_cnt < start + 3; i++) step();
    if (rise_cnt < start + 3) chk({name, "_timeout"}, rise_cnt - start, 3);
    else chk(name, rise_last - rise_prev, expected);
  endtask

  task automatic wait_rise(input string name);
    int start;
    start = rise_cnt;
    for (int i = 0; i < 200 && rise_cnt == start; i++) step();
    if (rise_cnt == start) chk({name, "_timeout"}, rise_cnt - start, 1);
  endtask

  task automatic wait_grav(input int g);
    int n;
    n = 0;
    while (!(m_grav == g && m_state == 1) && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) chk("wait_grav_timeout", m_grav, g);
  endtask

  task automatic start_run(output int t_run);
    reset_n = 1'b1; en = 1'b1;
    step();
    t_run = cyc;
  endtask

  initial begin
    int t_run, r0, rs, nref, nb;
    reset_n = 1'b0; en = 1'b0; pause = 1'b0; soft_drop = 1'b0;
    drop_ack = 1'b0; level = 4'd0;

    // Reset values
    step(); step();
    chk("rst_state", int'(state), 0);
    chk("rst_base_tick", int'(base_tick), 0);
    chk("rst_drop_req", int'(drop_req), 0);
    chk("rst_overrun", int'(overrun), 0);

    // Level 0 with prompt acks
    auto_ack = 1;
    bt_first = -1;
    start_run(t_run);
    chk("run_entered", int'(state), 1);
    for (int i = 0; i < 20 && bt_first < 0; i++) step();
    chk("first_base_tick_delay", bt_first - t_run, 4);
    wait_rise("first_drop");
    chk("first_drop_delay", rise_last - t_run, 41);
    measure("spacing_level0", 40);
    chk("no_overrun_acked", int'(overrun), 0);

    // Faster levels, including saturation to MIN_PERIOD
    level = 4'd5;
    measure("spacing_level5", 20);
    level = 4'd12;
    measure("spacing_level12", 8);

    // Soft drop override mid-period, then release
    level = 4'd0;
    wait_grav(6);
    soft_drop = 1'b1;
    r0 = rise_cnt;
    for (int i = 0; i < 6 && rise_cnt == r0; i++) step();
    chk("soft_fires_next_tick", rise_cnt - r0, 1);
    measure("spacing_soft", 4);
    wait_rise("soft_sync");
    soft_drop = 1'b0;
    rs = rise_last;
    wait_rise("soft_release");
    chk("soft_release_spacing", rise_last - rs, 40);

    // Pause at grav_cnt=7
    wait_grav(7);
    pause = 1'b1;
    r0 = rise_cnt;
    nref = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (refresh_tick) nref++;
    end
    chk("pause_state", int'(state), 2);
    chk("pause_no_drop", rise_cnt - r0, 0);
    chk("pause_refresh_count", nref, 7);
    pause = 1'b0;
    r0 = rise_cnt;
    nb = 0;
    for (int i = 0; i < 60 && rise_cnt == r0; i++) begin
      step();
      if (base_tick && state == 2'd1) nb++;
    end
    chk("pause_resume_ticks", nb, 3);

    // Unacked requests produce overrun; restart clears it
    auto_ack = 0;
    drop_ack = 1'b0;
    repeat (100) step();
    chk("noack_drop_req", int'(drop_req), 1);
    chk("noack_overrun", int'(overrun), 1);
    en = 1'b0;
    step();
    chk("en_low_idle", int'(state), 0);
    chk("en_low_req_clear", int'(drop_req), 0);
    en = 1'b1;
    step(); step();
    chk("restart_overrun_clear", int'(overrun), 0);
    chk("restart_req_clear", int'(drop_req), 0);

    // Reset mid-period with a pending request
    wait_rise("pre_reset_drop");
    repeat (6) step();
    reset_n = 1'b0;
    step();
    chk("midrst_state", int'(state), 0);
    chk("midrst_drop_req", int'(drop_req), 0);
    chk("midrst_base_tick", int'(base_tick), 0);
    chk("midrst_overrun", int'(overrun), 0);
    auto_ack = 1;
    start_run(t_run);
    wait_rise("post_reset_drop");
    chk("post_reset_drop_delay", rise_last - t_run, 41);

    // Random traffic against the model
    auto_ack = 0;
    for (int i = 0; i < 4000; i++) begin
      reset_n   = ($urandom_range(0, 199) != 0);
      en        = ($urandom_range(0, 79) != 0);
      if ($urandom_range(0, 19) == 0) pause = ~pause;
      if ($urandom_range(0, 19) == 0) soft_drop = ~soft_drop;
      if ($urandom_range(0, 49) == 0) level = 4'($urandom_range(0, 15));
      drop_ack  = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_tick_scheduler.md
Name: game_tick_scheduler

Overview:
- Central timing controller for the Tetris game logic.
- Replaces ad-hoc derived clocks with single-cycle clock-enable pulses on the one system clock:
  - base tick from a prescaler,
  - display refresh tick,
  - level-dependent gravity (drop) request, with soft-drop override, pause and a req/ack handshake to the piece controller.
- Sits between the top-level clock and the board/piece FSMs.

Parameters:
PRESCALE, 4, clk_in cycles per base tick (>=2)
CNT_W, 8, width of gravity counter and period arithmetic
START_PERIOD, 10, gravity period in base ticks at level 0
STEP, 1, period reduction per level
MIN_PERIOD, 2, floor of gravity period (>=1)
SOFT_PERIOD, 1, gravity period while soft_drop held (>=1)

Ports:
clk_in  input  1  system clock
reset_n  input  1  synchronous active-low reset
en  input  1  game running; low forces IDLE
pause  input  1  freeze gravity while high
level  input  4  current game level
soft_drop  input  1  use SOFT_PERIOD while high
drop_ack  input  1  piece controller consumed drop_req
base_tick  output  1  1-cycle pulse every PRESCALE cycles
refresh_tick  output  1  equal to base_tick; also pulses in PAUSED
drop_req  output  1  gravity request, held until acked
overrun  output  1  sticky: gravity fired while drop_req pending
state  output  2  0=IDLE 1=RUN 2=PAUSED

Behaviour:
- Clock and reset:
  - One clock, clk_in. All state updates on its rising edge.
  - Reset is synchronous, active-low on reset_n. It wins over every other input.
  - Reset values: state=IDLE, prescaler=0, grav_cnt=0, base_tick=0, refresh_tick=0, drop_req=0, overrun=0.
- FSM, evaluated each cycle in this priority:
  - en=0 -> IDLE.
  - Else pause=1 -> PAUSED.
  - Else -> RUN.
- IDLE:
  - Prescaler and grav_cnt held at 0; drop_req cleared; no ticks.
  - Transition IDLE->RUN (en rising) clears overrun.
- Prescaler:
  - Counts 0..PRESCALE-1 in RUN and PAUSED, then wraps.
  - base_tick is a registered pulse, high for exactly the cycle after prescaler==PRESCALE-1.
  - First base_tick is PRESCALE cycles after entering RUN.
  - Pause does not reset the prescaler.
- Gravity period P:
  - soft_drop=1 -> P=SOFT_PERIOD.
  - Else P=START_PERIOD-level*STEP, computed at CNT_W+4 bits with no underflow.
  - If level*STEP > START_PERIOD-MIN_PERIOD, then P=MIN_PERIOD.
- Gravity counter (RUN only, on base_tick):
  - If grav_cnt+1 >= P: fire, grav_cnt<=0.
  - Else grav_cnt<=grav_cnt+1.
  - The >= compare means a level increase or soft_drop assertion that leaves grav_cnt >= P-1 fires on the next base_tick; there is no wait for wrap.
  - Frozen (value held) in PAUSED.
- drop_req:
  - Set the cycle after fire; stays high until a cycle with drop_ack=1, then clears next cycle.
  - drop_ack while drop_req=0 is ignored.
  - Fire in the same cycle as the acking drop_ack: drop_req stays high (new request); overrun not set.
  - Fire while drop_req high and no ack: overrun<=1 sticky; drop_req stays single (no queueing).
  - drop_req is retained across PAUSED; it is cleared only by ack, IDLE or reset.
- Mid-operation:
  - Reset at any point returns all outputs to reset values the next cycle.
  - en drop mid-period discards partial counts.
- Size: RTL fits 120-400 lines. Period computation is combinational; all outputs are registered.

Test Plan:
1. Reset, en=1, level=0, ack drop_req one cycle after each rise -> base_tick every 4 cycles, first 4 cycles after RUN; drop_req rises the cycle after every 10th base_tick (40-cycle spacing); overrun=0.
2. level=5, then level=12 -> drop spacing 5 base ticks (20 cycles), then 2 base ticks (8 cycles; saturation to MIN_PERIOD, no underflow wrap).
3. level=0, after grav_cnt reaches 6 assert soft_drop -> fire on the next base_tick, then every base tick; release -> 10-tick spacing resumes from grav_cnt=0.
4. Never assert drop_ack over 25 base ticks -> drop_req high from first fire, overrun=1 after second fire; en low then high -> overrun=0, drop_req=0.
5. pause=1 at grav_cnt=7 for 30 cycles -> state=2, refresh_tick keeps pulsing every 4 cycles, no drop_req; release -> fire after 3 further base ticks.
6. reset_n low for 1 cycle mid-period with drop_req=1 -> next cycle all outputs 0, state=IDLE; en held 1 -> RUN resumes with full 10-tick period.
